// File: rtl/rr_stream_mux.sv
// rr_stream_mux -- N-to-1 valid/ready stream multiplexer, round-robin arbitration.
//
// Merges N producer streams into one registered output stream and tags each
// output beat with the index of the channel it came from. With PACKET_MODE=1
// a channel that wins keeps the grant until its s_last beat is accepted.
//
// Ports:
//   clk, resetn        clock, asynchronous active-low reset
//   s_valid/s_ready    per-channel handshake (s_ready is at most one-hot)
//   s_data             channel i in bits [i*DATA_WIDTH +: DATA_WIDTH]
//   s_last             per-channel end-of-packet
//   m_valid/m_ready    output handshake (m_valid registered)
//   m_data/m_last      registered output payload / end-of-packet
//   m_src              registered source channel index of the current beat

// Per-channel slice: round-robin "above pointer" request and ready decode.
module rr_stream_mux_lane #(
    parameter int IDX_W = 3,
    parameter int LANE  = 0
) (
    input  logic             resetn,
    input  logic             valid,
    input  logic [IDX_W-1:0] ptr,
    input  logic [IDX_W-1:0] grant,
    input  logic             gvalid,
    input  logic             load_en,
    output logic             req_hi,
    output logic             ready
);
    localparam logic [IDX_W-1:0] MY_IDX = IDX_W'(LANE);

    // Requests strictly after the last winner get first pick; this is what
    // makes the search start at ptr+1 and wrap modulo N.
    assign req_hi = valid & (MY_IDX > ptr);
    assign ready  = resetn & load_en & gvalid & (grant == MY_IDX);
endmodule

module rr_stream_mux #(
    parameter int DATA_WIDTH  = 32,
    parameter int N           = 8,
    parameter int PACKET_MODE = 0,
    localparam int IDX_W      = (N > 1) ? $clog2(N) : 1
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic [N-1:0]            s_valid,
    output logic [N-1:0]            s_ready,
    input  logic [N*DATA_WIDTH-1:0] s_data,
    input  logic [N-1:0]            s_last,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic [DATA_WIDTH-1:0]   m_data,
    output logic                    m_last,
    output logic [IDX_W-1:0]        m_src
);
    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        logic                  last;
        logic [IDX_W-1:0]      src;
    } beat_t;

    logic [N-1:0][DATA_WIDTH-1:0] lane_data;
    logic [N-1:0]                 req_hi;
    logic [IDX_W-1:0]             ptr, lock_idx, grant, rr_hi, rr_lo;
    logic                         lock, gvalid, load_en, xfer, vld_q;
    beat_t                        beat_q, beat_d;

    assign lane_data = s_data;
    assign load_en   = !vld_q | m_ready;
    assign xfer      = |(s_valid & s_ready);

    for (genvar i = 0; i < N; i++) begin : g_lane
        rr_stream_mux_lane #(.IDX_W(IDX_W), .LANE(i)) u_lane (
            .resetn  (resetn),
            .valid   (s_valid[i]),
            .ptr     (ptr),
            .grant   (grant),
            .gvalid  (gvalid),
            .load_en (load_en),
            .req_hi  (req_hi[i]),
            .ready   (s_ready[i])
        );
    end

    // Arbitration. Descending loops so the lowest matching index wins.
    always_comb begin
        rr_hi  = '0;
        rr_lo  = '0;
        grant  = '0;
        gvalid = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req_hi[i])  rr_hi = IDX_W'(i);
            if (s_valid[i]) rr_lo = IDX_W'(i);
        end
        if (lock) begin
            // Locked channel only; everyone else is held off.
            grant = lock_idx;
            for (int i = 0; i < N; i++)
                if (IDX_W'(i) == lock_idx) gvalid = s_valid[i];
        end else begin
            grant  = (|req_hi) ? rr_hi : rr_lo;
            gvalid = |s_valid;
        end
    end

    // Payload select for the granted channel.
    always_comb begin
        beat_d     = '0;
        beat_d.src = grant;
        for (int i = 0; i < N; i++) begin
            if (grant == IDX_W'(i)) begin
                beat_d.data = lane_data[i];
                beat_d.last = s_last[i];
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            vld_q    <= 1'b0;
            beat_q   <= '0;
            ptr      <= IDX_W'(N - 1);
            lock     <= 1'b0;
            lock_idx <= '0;
        end else if (load_en) begin
            vld_q <= xfer;
            if (xfer) begin
                beat_q <= beat_d;
                ptr    <= grant;
                if (PACKET_MODE != 0) begin
                    // Single-beat packets never lock; unlocking leaves ptr at
                    // the finished channel so the next search starts after it.
                    if (!lock && !beat_d.last) begin
                        lock     <= 1'b1;
                        lock_idx <= grant;
                    end else if (lock && beat_d.last) begin
                        lock <= 1'b0;
                    end
                end
            end
        end
    end

    assign m_valid = vld_q;
    assign m_data  = beat_q.data;
    assign m_last  = beat_q.last;
    assign m_src   = beat_q.src;
endmodule

// File: tb/tb_rr_stream_mux.sv
module tb_rr_stream_mux;
    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        int          src;
        logic [31:0] data;
        logic        last;
    } beat_t;
    beat_t qa[$], qb[$], qc[$], qd[$];

    // A: N=4 round-robin, B: N=4 packet mode, C: N=5, D: N=1
    logic [3:0]   a_s_valid = '0, a_s_ready, a_s_last = '0;
    logic [127:0] a_s_data = '0;
    logic         a_m_valid, a_m_ready = 1'b0, a_m_last;
    logic [31:0]  a_m_data;
    logic [1:0]   a_m_src;

    logic [3:0]   b_s_valid = '0, b_s_ready, b_s_last = '0;
    logic [127:0] b_s_data = '0;
    logic         b_m_valid, b_m_ready = 1'b0, b_m_last;
    logic [31:0]  b_m_data;
    logic [1:0]   b_m_src;

    logic [4:0]   c_s_valid = '0, c_s_ready, c_s_last = '0;
    logic [159:0] c_s_data = '0;
    logic         c_m_valid, c_m_ready = 1'b0, c_m_last;
    logic [31:0]  c_m_data;
    logic [2:0]   c_m_src;

    logic [0:0]   d_s_valid = '0, d_s_ready, d_s_last = '0;
    logic [31:0]  d_s_data = '0;
    logic         d_m_valid, d_m_ready = 1'b0, d_m_last;
    logic [31:0]  d_m_data;
    logic [0:0]   d_m_src;

    rr_stream_mux #(.DATA_WIDTH(32), .N(4), .PACKET_MODE(0)) u_a (
        .clk(clk), .resetn(resetn), .s_valid(a_s_valid), .s_ready(a_s_ready),
        .s_data(a_s_data), .s_last(a_s_last), .m_valid(a_m_valid), .m_ready(a_m_ready),
        .m_data(a_m_data), .m_last(a_m_last), .m_src(a_m_src));
    rr_stream_mux #(.DATA_WIDTH(32), .N(4), .PACKET_MODE(1)) u_b (
        .clk(clk), .resetn(resetn), .s_valid(b_s_valid), .s_ready(b_s_ready),
        .s_data(b_s_data), .s_last(b_s_last), .m_valid(b_m_valid), .m_ready(b_m_ready),
        .m_data(b_m_data), .m_last(b_m_last), .m_src(b_m_src));
    rr_stream_mux #(.DATA_WIDTH(32), .N(5), .PACKET_MODE(0)) u_c (
        .clk(clk), .resetn(resetn), .s_valid(c_s_valid), .s_ready(c_s_ready),
        .s_data(c_s_data), .s_last(c_s_last), .m_valid(c_m_valid), .m_ready(c_m_ready),
        .m_data(c_m_data), .m_last(c_m_last), .m_src(c_m_src));
    rr_stream_mux #(.DATA_WIDTH(32), .N(1), .PACKET_MODE(0)) u_d (
        .clk(clk), .resetn(resetn), .s_valid(d_s_valid), .s_ready(d_s_ready),
        .s_data(d_s_data), .s_last(d_s_last), .m_valid(d_m_valid), .m_ready(d_m_ready),
        .m_data(d_m_data), .m_last(d_m_last), .m_src(d_m_src));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic nx();
        @(posedge clk);
        #1;
    endtask

    // Scoreboards: pop one expected beat per output transfer.
    always @(negedge clk) begin
        beat_t e;
        if (resetn && a_m_valid && a_m_ready) begin
            chk("a_unexpected_beat", qa.size() != 0, 1);
            if (qa.size() != 0) begin
                e = qa.pop_front();
                chk("a_src", a_m_src, e.src); chk("a_data", a_m_data, e.data); chk("a_last", a_m_last, e.last);
            end
        end
    end
    always @(negedge clk) begin
        beat_t e;
        if (resetn && b_m_valid && b_m_ready) begin
            chk("b_unexpected_beat", qb.size() != 0, 1);
            if (qb.size() != 0) begin
                e = qb.pop_front();
                chk("b_src", b_m_src, e.src); chk("b_data", b_m_data, e.data); chk("b_last", b_m_last, e.last);
            end
        end
    end
    always @(negedge clk) begin
        beat_t e;
        if (resetn && c_m_valid && c_m_ready) begin
            chk("c_unexpected_beat", qc.size() != 0, 1);
            if (qc.size() != 0) begin
                e = qc.pop_front();
                chk("c_src", c_m_src, e.src); chk("c_data", c_m_data, e.data); chk("c_last", c_m_last, e.last);
            end
        end
    end
    always @(negedge clk) begin
        beat_t e;
        if (resetn && d_m_valid && d_m_ready) begin
            chk("d_unexpected_beat", qd.size() != 0, 1);
            if (qd.size() != 0) begin
                e = qd.pop_front();
                chk("d_src", d_m_src, e.src); chk("d_data", d_m_data, e.data); chk("d_last", d_m_last, e.last);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // ---- reset state ----
        #12;
        a_s_valid = 4'hF; a_m_ready = 1'b1;
        #1;
        chk("rst_m_valid", a_m_valid, 0);
        chk("rst_m_data",  a_m_data, 0);
        chk("rst_m_last",  a_m_last, 0);
        chk("rst_m_src",   a_m_src, 0);
        chk("rst_s_ready", a_s_ready, 0);
        a_s_valid = '0;
        #9 resetn = 1'b1;
        nx();

        // ---- N=4 fairness: all valid, order 0,1,2,3,0,... ----
        for (int i = 0; i < 4; i++) a_s_data[i*32 +: 32] = 32'hA0 + i;
        a_s_valid = 4'hF; a_m_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            #1;
            chk("rr_s_ready", a_s_ready, 64'd1 << (k % 4));
            if (k > 0) chk("rr_no_bubble", a_m_valid, 1);
            qa.push_back('{src: k % 4, data: 32'hA0 + 32'(k % 4), last: 1'b0});
            nx();
        end
        a_s_valid = '0;
        #1 chk("rr_tail_valid", a_m_valid, 1);
        nx();
        chk("rr_drain", a_m_valid, 0);

        // ---- single requester ch2 ----
        a_s_data[2*32 +: 32] = 32'h55; a_s_valid = 4'b0100;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("single_s_ready", a_s_ready, 4'b0100);
            chk("single_m_valid", a_m_valid, k > 0);
            qa.push_back('{src: 2, data: 32'h55, last: 1'b0});
            nx();
        end
        a_s_valid = '0;
        #1 chk("single_tail", a_m_valid, 1);
        nx();
        chk("single_drain", a_m_valid, 0);

        // ---- backpressure: ch0 then ch1 after 5 stall cycles ----
        a_s_data[0 +: 32] = 32'hC0; a_s_data[32 +: 32] = 32'hC1;
        a_s_valid = 4'b0011;
        #1 chk("bp_first_grant", a_s_ready, 4'b0001);
        qa.push_back('{src: 0, data: 32'hC0, last: 1'b0});
        nx();
        a_m_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("bp_s_ready", a_s_ready, 0);
            chk("bp_m_valid", a_m_valid, 1);
            chk("bp_m_data", a_m_data, 32'hC0);
            chk("bp_m_src", a_m_src, 0);
            nx();
        end
        a_m_ready = 1'b1;
        #1 chk("bp_next_grant", a_s_ready, 4'b0010);
        qa.push_back('{src: 1, data: 32'hC1, last: 1'b0});
        nx();
        a_s_valid = '0;
        #1 chk("bp_tail_src", a_m_src, 1);
        nx();
        chk("bp_drain", a_m_valid, 0);

        // ---- packet lock (B) ----
        b_m_ready = 1'b1;
        b_s_data[0 +: 32] = 32'hB0; b_s_data[96 +: 32] = 32'hB3;
        b_s_last = 4'b1001;
        b_s_valid = 4'b0001;
        #1 chk("pk_pre_grant", b_s_ready, 4'b0001);
        qb.push_back('{src: 0, data: 32'hB0, last: 1'b1});
        nx();
        b_s_valid = 4'b1011; b_s_data[32 +: 32] = 32'hD1;
        #1 chk("pk_beat1_ready", b_s_ready, 4'b0010);
        qb.push_back('{src: 1, data: 32'hD1, last: 1'b0});
        nx();
        b_s_data[32 +: 32] = 32'hD2;
        #1 chk("pk_beat2_ready", b_s_ready, 4'b0010);
        qb.push_back('{src: 1, data: 32'hD2, last: 1'b0});
        nx();
        b_s_valid = 4'b1001;
        #1 chk("pk_hold1_ready", b_s_ready, 0);
        nx();
        #1 chk("pk_hold2_ready", b_s_ready, 0);
        chk("pk_bubble1", b_m_valid, 0);
        nx();
        b_s_valid = 4'b1011; b_s_data[32 +: 32] = 32'hD3; b_s_last = 4'b1011;
        #1 chk("pk_beat3_ready", b_s_ready, 4'b0010);
        chk("pk_bubble2", b_m_valid, 0);
        qb.push_back('{src: 1, data: 32'hD3, last: 1'b1});
        nx();
        #1 chk("pk_after_last_grant", b_s_ready, 4'b1000);
        chk("pk_beat3_valid", b_m_valid, 1);
        qb.push_back('{src: 3, data: 32'hB3, last: 1'b1});
        nx();
        b_s_valid = '0;
        #1 chk("pk_tail_src", b_m_src, 3);
        nx();
        chk("pk_drain", b_m_valid, 0);

        // ---- async reset mid-packet (B locked on ch2, beat held) ----
        b_s_data[64 +: 32] = 32'hE2; b_s_last = 4'b0000; b_s_valid = 4'b0100;
        #1 chk("ar_lock_grant", b_s_ready, 4'b0100);
        nx();
        b_m_ready = 1'b0; b_s_valid = 4'hF;
        #1 chk("ar_pre_valid", b_m_valid, 1);
        resetn = 1'b0;
        #1;
        chk("ar_m_valid", b_m_valid, 0);
        chk("ar_m_data", b_m_data, 0);
        chk("ar_m_last", b_m_last, 0);
        chk("ar_m_src", b_m_src, 0);
        chk("ar_s_ready", b_s_ready, 0);
        nx();
        #2 resetn = 1'b1;
        b_m_ready = 1'b1; b_s_last = 4'hF;
        for (int i = 0; i < 4; i++) b_s_data[i*32 +: 32] = 32'hF0 + i;
        #1 chk("ar_first_grant", b_s_ready, 4'b0001);
        qb.push_back('{src: 0, data: 32'hF0, last: 1'b1});
        nx();
        b_s_valid = '0;
        #1 chk("ar_out_valid", b_m_valid, 1);
        nx();
        chk("ar_drain", b_m_valid, 0);

        // ---- N=5 wrap and N=1 register slice ----
        for (int i = 0; i < 5; i++) c_s_data[i*32 +: 32] = 32'h50 + i;
        c_s_valid = 5'h1F; c_m_ready = 1'b1;
        d_s_valid = 1'b1; d_m_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            d_s_data = 32'h11 * (k + 1);
            d_s_last = 1'(k & 1);
            #1;
            chk("n5_s_ready", c_s_ready, 64'd1 << (k % 5));
            chk("n1_s_ready", d_s_ready, 1);
            chk("n1_m_valid", d_m_valid, k > 0);
            if (k > 0) chk("n1_latency_data", d_m_data, 32'h11 * k);
            qc.push_back('{src: k % 5, data: 32'h50 + 32'(k % 5), last: 1'b0});
            qd.push_back('{src: 0, data: 32'h11 * (k + 1), last: 1'(k & 1)});
            nx();
        end
        c_s_valid = '0; d_s_valid = '0;
        nx();
        chk("n5_drain", c_m_valid, 0);
        chk("n1_drain", d_m_valid, 0);
        nx();

        chk("qa_left", qa.size(), 0);
        chk("qb_left", qb.size(), 0);
        chk("qc_left", qc.size(), 0);
        chk("qd_left", qd.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
